// File: rtl/uart_tx_if.sv
// Byte handshake between a data producer and the UART transmitter.
// The producer raises start with data; the transmitter reports ready when idle.
`timescale 1ns/1ps
interface uart_tx_if;
  logic       start;
  logic [7:0] data;
  logic       ready;

  modport master (output start, output data, input ready);
  modport slave  (input start, input data, output ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1/8E1/8O1 UART transmitter, LSB first, one bit every BAUD clocks.
// tx is registered from the next-state value so the pin has no combinational path.
`timescale 1ns/1ps
module uart_tx #(
  parameter int BAUD   = 104,
  parameter int PARITY = 0
) (
  input  logic     clk,
  input  logic     rstn,
  uart_tx_if.slave bus,
  output logic     tx
);
  // state  | meaning
  // IDLE   | line at mark, ready for a byte
  // START  | driving the start bit (0)
  // DATA   | shifting holding[bitc], LSB first
  // PARITY | driving the parity bit
  // STOP   | driving the stop bit (1)
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam int             DW       = $clog2(BAUD);
  localparam logic [DW-1:0]  DIV_LAST = DW'(BAUD - 1);
  localparam bit             USE_PAR  = (PARITY == 1) || (PARITY == 2);
  localparam bit             ODD_PAR  = (PARITY == 2);

  state_t        state_q, state_d;
  logic [DW-1:0] divc_q, divc_d;
  logic [3:0]    bitc_q, bitc_d;
  logic [7:0]    hold_q, hold_d;
  logic          tx_q, tx_d;
  logic          ready_q, ready_d;
  logic          tick;
  logic          par_bit;

  assign tick      = (divc_q == DIV_LAST);
  assign par_bit   = (^hold_q) ^ ODD_PAR;
  assign tx        = tx_q;
  assign bus.ready = ready_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      divc_q  <= '0;
      bitc_q  <= '0;
      hold_q  <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      divc_q  <= divc_d;
      bitc_q  <= bitc_d;
      hold_q  <= hold_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bitc_d  = bitc_q;
    hold_d  = hold_q;
    divc_d  = '0;
    tx_d    = 1'b1;
    ready_d = 1'b0;

    if (state_q != S_IDLE) divc_d = tick ? '0 : divc_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.start && ready_q) begin
          hold_d  = bus.data;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          bitc_d  = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          bitc_d = bitc_q + 4'd1;
          if (bitc_q == 4'd7) state_d = USE_PAR ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (tick) state_d = S_STOP;
      S_STOP:   if (tick) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Outputs follow the state being entered, so tx and ready change on the same edge.
    ready_d = (state_d == S_IDLE);
    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = hold_q[bitc_d[2:0]];
      S_PARITY: tx_d = par_bit;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end
endmodule
